// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the producers, the arbiter and the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 64,
    parameter int unsigned IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                wb_stall;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic [IDW-1:0]      grant_id;

    modport slave (
        input  req_valid, req_addr, req_data, wb_stall,
        output req_ready, we, wa, wd, grant_id
    );

    modport master (
        output req_valid, req_addr, req_data, wb_stall,
        input  req_ready, we, wa, wd, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the single register file write port from registers.
// Optional macro WB_ZERO_REG_DROP_EN: requests to register 31 are acknowledged but never written.
module regfile_wb_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 64,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned SW = IDW + 1;

    logic [AW-1:0]    addr_a [N_REQ];
    logic [DW-1:0]    data_a [N_REQ];

    logic [IDW-1:0]   ptr;
    logic             we_q;
    logic [AW-1:0]    wa_q;
    logic [DW-1:0]    wd_q;
    logic [IDW-1:0]   gid_q;

    logic             found;
    logic [IDW-1:0]   sel;
    logic [IDW-1:0]   idx;
    logic [SW-1:0]    sum;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [IDW-1:0]   ptr_nxt;
    logic [N_REQ-1:0] ready_c;
    logic             drop;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_a[i] = bus.req_addr[i*AW +: AW];
        assign data_a[i] = bus.req_data[i*DW +: DW];
    end

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        idx      = '0;
        sum      = '0;
        sel_addr = '0;
        sel_data = '0;
        if (!reset && !bus.wb_stall) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr} + SW'(k);
                if (sum >= SW'(N_REQ)) begin
                    sum = sum - SW'(N_REQ);
                end
                idx = sum[IDW-1:0];
                if (!found && bus.req_valid[idx]) begin
                    found    = 1'b1;
                    sel      = idx;
                    sel_addr = addr_a[idx];
                    sel_data = data_a[idx];
                end
            end
        end
        ptr_nxt = (sel == IDW'(N_REQ - 1)) ? '0 : sel + IDW'(1);
        ready_c = found ? (N_REQ'(1) << sel) : '0;
    end

`ifdef WB_ZERO_REG_DROP_EN
    assign drop = (sel_addr == AW'(31));
`else
    assign drop = 1'b0;
`endif

    // Output registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            we_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            gid_q <= '0;
        end else begin
            we_q <= found & ~drop;
            if (found) begin
                ptr   <= ptr_nxt;
                wa_q  <= sel_addr;
                wd_q  <= sel_data;
                gid_q <= sel;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.grant_id  = gid_q;
endmodule
